// File: rtl/node_input_framer_pkg.sv
// Shared constants and out_vec packing helper for the layer-4 node framer.
package node_input_framer_pkg;

  localparam int unsigned NODE_FANIN = 15;
  localparam int unsigned FLOAT_W    = 32;

  // Bit offset of word k inside a flat vector of w-bit words (A0 at the LSBs).
  function automatic int unsigned word_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/framer_bank.sv
// One ping-pong bank: N-word register file with a single write port and a full flag.
module framer_bank
  import node_input_framer_pkg::*;
#(
  parameter  int unsigned N  = NODE_FANIN,
  parameter  int unsigned W  = FLOAT_W,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IW-1:0]       idx,
  input  logic [W-1:0]        wdata,
  input  logic                set,
  input  logic                clr,
  output logic [N-1:0][W-1:0] data,
  output logic                full
);

  // Word storage and full flag; storage is cleared only by reset so out_vec reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (we) begin
        data[idx] <= wdata;
      end
      if (set) begin
        full <= 1'b1;
      end else if (clr) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/node_input_framer.sv
// Serial-to-parallel framer: collects N float words into one of two banks and presents
// completed frames to a layer-4 node while the other bank fills.
module node_input_framer
  import node_input_framer_pkg::*;
#(
  parameter int unsigned N = NODE_FANIN,
  parameter int unsigned W = FLOAT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  output logic [N*W-1:0] out_vec,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           frame_err
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0]       cnt;
  logic                wr_sel;
  logic                rd_sel;
  logic [1:0]          full;
  logic [N-1:0][W-1:0] data0;
  logic [N-1:0][W-1:0] data1;
  logic                accept;
  logic                at_end;
  logic                push;
  logic                pop;
  logic                bad_len;

  // Handshake decode; a bank can only be written while its full flag is clear.
  assign in_ready  = !rst && !full[wr_sel];
  assign accept    = in_valid && in_ready;
  assign at_end    = (cnt == IW'(N - 1));
  assign push      = accept && at_end && in_last;
  assign bad_len   = accept && (at_end ^ in_last);
  assign out_valid = full[rd_sel];
  assign pop       = out_valid && out_ready;

  // Word counter, bank pointers and registered length-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= (at_end || in_last) ? '0 : cnt + IW'(1);
      end
      if (push) begin
        wr_sel <= ~wr_sel;
      end
      if (pop) begin
        rd_sel <= ~rd_sel;
      end
      frame_err <= bad_len;
    end
  end

  framer_bank #(.N(N), .W(W)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && !wr_sel),
    .idx   (cnt),
    .wdata (in_data),
    .set   (push && !wr_sel),
    .clr   (pop && !rd_sel),
    .data  (data0),
    .full  (full[0])
  );

  framer_bank #(.N(N), .W(W)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && wr_sel),
    .idx   (cnt),
    .wdata (in_data),
    .set   (push && wr_sel),
    .clr   (pop && rd_sel),
    .data  (data1),
    .full  (full[1])
  );

  // Output mux: present the bank addressed by rd_sel, word k at bits [k*W +: W].
  for (genvar k = 0; k < int'(N); k++) begin : g_word
    assign out_vec[word_lsb(k, W) +: W] = rd_sel ? data1[k] : data0[k];
  end

endmodule

// File: tb/tb_node_input_framer.sv
// Directed testbench for node_input_framer.
module tb_node_input_framer;

  localparam int unsigned N = 15;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [N*W-1:0] out_vec;
  logic           out_valid;
  logic           out_ready;
  logic           frame_err;

  int total = 0;
  int bad   = 0;

  node_input_framer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_vec   (out_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Word k of frame f.
  function automatic logic [W-1:0] word_of(input int f, input int k);
    return 32'h3F80_0000 + 32'(f * 256) + 32'(k);
  endfunction

  // Full expected out_vec for frame f.
  function automatic logic [N*W-1:0] frame_vec(input int f);
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < int'(N); k++) v[k*W +: W] = word_of(f, k);
    return v;
  endfunction

  // Advance one clock; outputs and inputs are handled 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one word and wait (bounded) until it is accepted.
  task automatic send_word(input int f, input int k, input logic last, output bit ok);
    int budget;
    budget   = 50;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = word_of(f, k);
    in_last  = last;
    while (budget > 0) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
      budget--;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Send n words of frame f with in_last on word last_idx (-1: never).
  task automatic send_frame(input int f, input int n, input int last_idx, output bit ok);
    bit w_ok;
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      send_word(f, k, (k == last_idx), w_ok);
      ok = ok && w_ok;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%0b want=0", frame_err); end
    total++; if (out_vec !== '0) begin bad++; $display("FAIL reset_out_vec got=%h want=0", out_vec); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_single_frame;
    bit ok;
    out_ready = 1'b1;
    for (int k = 0; k < int'(N); k++) begin
      send_word(0, k, (k == int'(N) - 1), ok);
      total++; if (!ok) begin bad++; $display("FAIL single_accept_timeout word=%0d got=0 want=1", k); end
      if (k < int'(N) - 1) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid word=%0d got=%0b want=0", k, out_valid); end
      end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL single_frame_err word=%0d got=%0b want=0", k, frame_err); end
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%0b want=1", out_valid); end
    total++; if (out_vec !== frame_vec(0)) begin bad++; $display("FAIL single_out_vec got=%h want=%h", out_vec, frame_vec(0)); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%0b want=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2, ok3;
    out_ready = 1'b0;
    send_frame(1, N, N - 1, ok1);
    send_frame(2, N, N - 1, ok2);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL b2b_accept_timeout got=%0b%0b want=11", ok1, ok2); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_both_full_in_ready got=%0b want=0", in_ready); end
    total++; if (out_vec !== frame_vec(1)) begin bad++; $display("FAIL b2b_frame1 got=%h want=%h", out_vec, frame_vec(1)); end
    in_valid = 1'b1; in_data = word_of(3, 0); in_last = 1'b0;
    tick(); tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_in_ready got=%0b want=0", in_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_hold_valid got=%0b want=1", out_valid); end
    total++; if (out_vec !== frame_vec(1)) begin bad++; $display("FAIL b2b_frame1_stable got=%h want=%h", out_vec, frame_vec(1)); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_vec !== frame_vec(2)) begin bad++; $display("FAIL b2b_frame2 got=%h want=%h", out_vec, frame_vec(2)); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_pop got=%0b want=1", in_ready); end
    send_frame(3, N, N - 1, ok3);
    total++; if (!ok3) begin bad++; $display("FAIL b2b_frame3_timeout got=0 want=1"); end
    total++; if (out_vec !== frame_vec(2)) begin bad++; $display("FAIL b2b_frame2_held got=%h want=%h", out_vec, frame_vec(2)); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_frame3_valid got=%0b want=1", out_valid); end
    total++; if (out_vec !== frame_vec(3)) begin bad++; $display("FAIL b2b_frame3 got=%h want=%h", out_vec, frame_vec(3)); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%0b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_short_frame;
    bit ok;
    out_ready = 1'b1;
    send_frame(4, 7, 6, ok);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL short_err_pulse got=%0b want=1", frame_err); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL short_no_present got=%0b want=0", out_valid); end
    tick();
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL short_err_once got=%0b want=0", frame_err); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL short_still_empty got=%0b want=0", out_valid); end
    send_frame(5, N, N - 1, ok);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL short_next_valid got=%0b want=1", out_valid); end
    total++; if (out_vec !== frame_vec(5)) begin bad++; $display("FAIL short_next_vec got=%h want=%h", out_vec, frame_vec(5)); end
    tick();
  endtask

  task automatic test_long_frame;
    bit ok;
    out_ready = 1'b1;
    send_frame(6, N, -1, ok);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL long_err_pulse got=%0b want=1", frame_err); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL long_discard got=%0b want=0", out_valid); end
    tick();
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL long_err_once got=%0b want=0", frame_err); end
    send_frame(7, N, N - 1, ok);
    total++; if (out_vec !== frame_vec(7)) begin bad++; $display("FAIL long_next_vec got=%h want=%h", out_vec, frame_vec(7)); end
    tick();
  endtask

  task automatic test_pop_push_same;
    bit ok;
    out_ready = 1'b0;
    send_frame(8, N, N - 1, ok);
    send_frame(9, N - 1, -1, ok);
    in_valid = 1'b1; in_data = word_of(9, N - 1); in_last = 1'b1; out_ready = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL same_in_ready got=%0b want=1", in_ready); end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL same_out_valid got=%0b want=1", out_valid); end
    total++; if (out_vec !== frame_vec(9)) begin bad++; $display("FAIL same_out_vec got=%h want=%h", out_vec, frame_vec(9)); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL same_frame_err got=%0b want=0", frame_err); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL same_drained got=%0b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    out_ready = 1'b0;
    send_frame(10, N, N - 1, ok);
    send_frame(11, 9, -1, ok);
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_in_ready_during got=%0b want=0", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%0b want=0", out_valid); end
    total++; if (out_vec !== '0) begin bad++; $display("FAIL rstmid_out_vec got=%h want=0", out_vec); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_release got=%0b want=1", in_ready); end
    out_ready = 1'b1;
    send_frame(12, N, N - 1, ok);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_frame_err got=%0b want=0", frame_err); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_clean_valid got=%0b want=1", out_valid); end
    total++; if (out_vec !== frame_vec(12)) begin bad++; $display("FAIL rstmid_clean_vec got=%h want=%h", out_vec, frame_vec(12)); end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_short_frame();
    test_long_frame();
    test_pop_push_same();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
